// File: rtl/l2_set_assoc_store.sv
// N-way set-associative tag/state/data store with MESI state, per-way LRU ranks and victim reporting.
// Optional hit/miss counters are compiled in when L2_STORE_STATS_EN is defined.
module l2_set_assoc_store #(
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int LINE_BITS  = 512,
  parameter int WAYS       = 8,
  localparam int WAY_BITS  = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef L2_STORE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [LINE_BITS-1:0]  req_data,
  input  logic [1:0]            req_state,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_BITS-1:0]   resp_way,
  output logic [LINE_BITS-1:0]  resp_data,
  output logic [1:0]            resp_state,
  output logic                  evict_valid,
  output logic [TAG_BITS-1:0]   evict_tag,
  output logic                  evict_dirty
);
  localparam int SETS = 2 ** INDEX_BITS;
  localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_FILL = 2'b10, OP_INVAL = 2'b11;
  localparam logic [1:0] MESI_I = 2'b00, MESI_M = 2'b11;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_RESP} state_t;

  logic [WAYS-1:0][TAG_BITS-1:0]  tag_mem  [SETS];
  logic [WAYS-1:0][LINE_BITS-1:0] data_mem [SETS];
  logic [WAYS-1:0][1:0]           mesi_mem [SETS];
  logic [WAYS-1:0][WAY_BITS-1:0]  rank_mem [SETS];

  state_t state, next_state;
  logic [INDEX_BITS-1:0] init_idx, idx_r;
  logic [1:0] op_r, st_r;
  logic [TAG_BITS-1:0] tag_r;
  logic [LINE_BITS-1:0] data_r;
  logic hit_r, lk_hit, inv_found, touch;
  logic [WAY_BITS-1:0] way_r, lk_hit_way, inv_way, lru_way, sel_way;

  logic [WAYS-1:0][TAG_BITS-1:0]  set_tag, new_tag;
  logic [WAYS-1:0][LINE_BITS-1:0] set_data, new_data;
  logic [WAYS-1:0][1:0]           set_mesi, new_mesi;
  logic [WAYS-1:0][WAY_BITS-1:0]  set_rank, new_rank;
  logic [1:0] old_mesi;
  logic [WAY_BITS-1:0] old_rank;
  logic evict_cond;

  function automatic logic [WAYS-1:0][WAY_BITS-1:0] init_ranks();
    logic [WAYS-1:0][WAY_BITS-1:0] r;
    for (int w = 0; w < WAYS; w++) r[w] = WAY_BITS'(w);
    return r;
  endfunction

  assign req_ready = (state == S_IDLE);
  assign set_tag   = tag_mem[idx_r];
  assign set_data  = data_mem[idx_r];
  assign set_mesi  = mesi_mem[idx_r];
  assign set_rank  = rank_mem[idx_r];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = (init_idx == {INDEX_BITS{1'b1}}) ? S_IDLE : S_INIT;
      S_IDLE:   next_state = req_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP: next_state = S_RESP;
      S_RESP:   next_state = S_IDLE;
      default:  next_state = S_INIT;
    endcase
  end

  // Init sweep index and request capture at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx <= {INDEX_BITS{1'b0}};
      op_r <= 2'b00; idx_r <= {INDEX_BITS{1'b0}}; tag_r <= {TAG_BITS{1'b0}};
      data_r <= {LINE_BITS{1'b0}}; st_r <= 2'b00;
    end else begin
      init_idx <= (state == S_INIT) ? init_idx + 1'b1 : {INDEX_BITS{1'b0}};
      if (state == S_IDLE && req_valid) begin
        op_r <= req_op; idx_r <= req_index; tag_r <= req_tag;
        data_r <= req_data; st_r <= req_state;
      end
    end
  end

  // Tag compare (lowest matching way wins) and victim candidates
  always_comb begin
    lk_hit = 1'b0; lk_hit_way = {WAY_BITS{1'b0}};
    inv_found = 1'b0; inv_way = {WAY_BITS{1'b0}}; lru_way = {WAY_BITS{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_mesi[w] != MESI_I && set_tag[w] == tag_r) begin
        lk_hit = 1'b1; lk_hit_way = WAY_BITS'(w);
      end else begin
        lk_hit = lk_hit;
      end
      if (set_mesi[w] == MESI_I) begin
        inv_found = 1'b1; inv_way = WAY_BITS'(w);
      end else begin
        inv_found = inv_found;
      end
      if (set_rank[w] == WAY_BITS'(WAYS - 1)) lru_way = WAY_BITS'(w);
      else                                    lru_way = lru_way;
    end
    sel_way = lk_hit ? lk_hit_way : (inv_found ? inv_way : lru_way);
  end

  // Lookup result register
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_r <= 1'b0; way_r <= {WAY_BITS{1'b0}};
    end else if (state == S_LOOKUP) begin
      hit_r <= lk_hit; way_r <= sel_way;
    end else begin
      hit_r <= hit_r; way_r <= way_r;
    end
  end

  // Set update computed during RESP; ranks stay a permutation because only ranks below the touched one shift
  always_comb begin
    new_tag = set_tag; new_data = set_data; new_mesi = set_mesi; new_rank = set_rank;
    old_mesi = set_mesi[way_r]; old_rank = set_rank[way_r];
    touch = 1'b0;
    case (op_r)
      OP_READ:  touch = hit_r;
      OP_WRITE: begin
        if (hit_r) begin
          new_data[way_r] = data_r; new_mesi[way_r] = MESI_M; touch = 1'b1;
        end else begin
          touch = 1'b0;
        end
      end
      OP_FILL: begin
        new_tag[way_r] = tag_r; new_data[way_r] = data_r; new_mesi[way_r] = st_r;
        touch = (st_r != MESI_I);
      end
      OP_INVAL: begin
        if (hit_r) new_mesi[way_r] = MESI_I;
        else       new_mesi = set_mesi;
      end
      default: touch = 1'b0;
    endcase
    if (touch) begin
      for (int v = 0; v < WAYS; v++) begin
        if (WAY_BITS'(v) == way_r)       new_rank[v] = {WAY_BITS{1'b0}};
        else if (set_rank[v] < old_rank) new_rank[v] = set_rank[v] + 1'b1;
        else                             new_rank[v] = set_rank[v];
      end
    end else begin
      new_rank = set_rank;
    end
    evict_cond = (op_r == OP_FILL) && !hit_r && (old_mesi != MESI_I);
  end

  // Array writes: init sweep, or commit of the update on the RESP edge
  always_ff @(posedge clk) begin
    if (!rst && state == S_INIT) begin
      tag_mem[init_idx]  <= {WAYS{{TAG_BITS{1'b0}}}};
      data_mem[init_idx] <= {WAYS{{LINE_BITS{1'b0}}}};
      mesi_mem[init_idx] <= {WAYS{MESI_I}};
      rank_mem[init_idx] <= init_ranks();
    end else if (!rst && state == S_RESP) begin
      tag_mem[idx_r]  <= new_tag;
      data_mem[idx_r] <= new_data;
      mesi_mem[idx_r] <= new_mesi;
      rank_mem[idx_r] <= new_rank;
    end
  end

  // Response registers: resp_* hold between responses, evict_* only pulse with resp_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0; resp_hit <= 1'b0; resp_way <= {WAY_BITS{1'b0}};
      resp_data <= {LINE_BITS{1'b0}}; resp_state <= 2'b00;
      evict_valid <= 1'b0; evict_tag <= {TAG_BITS{1'b0}}; evict_dirty <= 1'b0;
    end else if (state == S_RESP) begin
      resp_valid  <= 1'b1;
      resp_hit    <= hit_r;
      resp_way    <= (hit_r || op_r == OP_FILL) ? way_r : {WAY_BITS{1'b0}};
      resp_data   <= (hit_r && op_r == OP_READ) ? set_data[way_r] : {LINE_BITS{1'b0}};
      resp_state  <= hit_r ? old_mesi : 2'b00;
      evict_valid <= evict_cond;
      evict_tag   <= evict_cond ? set_tag[way_r] : {TAG_BITS{1'b0}};
      evict_dirty <= evict_cond && (old_mesi == MESI_M);
    end else begin
      resp_valid <= 1'b0; evict_valid <= 1'b0;
      evict_tag <= {TAG_BITS{1'b0}}; evict_dirty <= 1'b0;
    end
  end

`ifdef L2_STORE_STATS_EN
  // Saturating hit/miss counters for READ and WRITE responses
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count <= 32'd0; miss_count <= 32'd0;
    end else if (state == S_RESP && (op_r == OP_READ || op_r == OP_WRITE)) begin
      if (hit_r && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 32'd1;
      else if (!hit_r && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      else begin
        hit_count <= hit_count; miss_count <= miss_count;
      end
    end else begin
      hit_count <= hit_count; miss_count <= miss_count;
    end
  end
`endif
endmodule

// File: tb/tb_l2_set_assoc_store.sv
// Directed, table-driven bench for l2_set_assoc_store (16 sets, 8 ways, 32-bit lines).
module tb_l2_set_assoc_store;
  localparam int IB = 4, TB = 12, LB = 32, NW = 8;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, FL = 2'b10, IV = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, req_valid = 1'b0, req_ready;
  logic [1:0] req_op = 2'b00, req_state = 2'b00, resp_state;
  logic [IB-1:0] req_index = 4'd0;
  logic [TB-1:0] req_tag = 12'd0, evict_tag;
  logic [LB-1:0] req_data = 32'd0, resp_data;
  logic resp_valid, resp_hit, evict_valid, evict_dirty;
  logic [2:0] resp_way;
`ifdef L2_STORE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  l2_set_assoc_store #(.INDEX_BITS(IB), .TAG_BITS(TB), .LINE_BITS(LB), .WAYS(NW)) dut (
    .clk(clk), .rst(rst),
`ifdef L2_STORE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_index(req_index),
    .req_tag(req_tag), .req_data(req_data), .req_state(req_state),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_data(resp_data),
    .resp_state(resp_state), .evict_valid(evict_valid), .evict_tag(evict_tag),
    .evict_dirty(evict_dirty));

  int errors = 0, checks = 0;

  typedef struct {
    logic [1:0] op; logic [3:0] idx; logic [11:0] tag; logic [31:0] data; logic [1:0] st;
    logic e_hit; logic [2:0] e_way; logic [31:0] e_data; logic [1:0] e_st;
    logic e_ev; logic [11:0] e_evtag; logic e_evd;
    logic cw; logic cs; logic cd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] tag,
                     input logic [31:0] data, input logic [1:0] st, input logic e_hit,
                     input logic [2:0] e_way, input logic [31:0] e_data, input logic [1:0] e_st,
                     input logic e_ev, input logic [11:0] e_evtag, input logic e_evd,
                     input logic cw, input logic cs, input logic cd);
    vec_t v;
    v.op = op; v.idx = idx; v.tag = tag; v.data = data; v.st = st;
    v.e_hit = e_hit; v.e_way = e_way; v.e_data = e_data; v.e_st = e_st;
    v.e_ev = e_ev; v.e_evtag = e_evtag; v.e_evd = e_evd; v.cw = cw; v.cs = cs; v.cd = cd;
    vecs.push_back(v);
  endtask

  // Starts and ends on a falling edge; fields are scrambled after acceptance.
  task automatic do_req(input string nm, input logic [1:0] op, input logic [3:0] idx,
                        input logic [11:0] tag, input logic [31:0] data, input logic [1:0] st);
    int t, lat;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) chk({nm, ".ready_timeout"}, 64'd0, 64'd1);
    req_valid = 1'b1; req_op = op; req_index = idx; req_tag = tag; req_data = data; req_state = st;
    @(posedge clk); #1;
    req_valid = 1'b0; req_tag = ~tag; req_data = ~data; req_index = ~idx; req_op = ~op; req_state = ~st;
    lat = 0;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    chk({nm, ".latency"}, 64'(lat), 64'd3);
  endtask

  // Entered on a falling edge; rst spans exactly one rising edge, then INIT length is measured.
  task automatic reset_pulse(input string nm);
    int n; logic seen;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({nm, ".rst_ready"}, 64'(req_ready), 64'd0);
    chk({nm, ".rst_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({nm, ".rst_outs"}, {resp_hit, resp_way, resp_state, evict_valid, evict_dirty, evict_tag, resp_data}, 64'd0);
    rst = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
      if (req_ready) break;
    end
    chk({nm, ".init_cycles"}, 64'(n), 64'd16);
    chk({nm, ".no_resp_in_init"}, 64'(seen), 64'd0);
  endtask

  initial begin
    // op idx tag data st | hit way data state ev evtag evd | cw cs cd
    add(RD, 4'd3, 12'h0AB, 32'h0, 2'd0,          1'b0, 3'd0, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 1'b1);
    add(FL, 4'd5, 12'h123, 32'hDEAD, 2'd2,       1'b0, 3'd0, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 1'b0);
    add(RD, 4'd5, 12'h123, 32'h0, 2'd0,          1'b1, 3'd0, 32'hDEAD, 2'd2, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b1);
    add(WR, 4'd5, 12'h123, 32'hBEEF, 2'd0,       1'b1, 3'd0, 32'h0,    2'd2, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b0);
    add(RD, 4'd5, 12'h123, 32'h0, 2'd0,          1'b1, 3'd0, 32'hBEEF, 2'd3, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++)
      add(FL, 4'd5, 12'h200 + 12'(k), 32'h2000 + 32'(k), 2'd1,
          1'b0, 3'(k + 1), 32'h0, 2'd0, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(FL, 4'd5, 12'h300, 32'h3000, 2'd2,       1'b0, 3'd0, 32'h0,    2'd0, 1'b1, 12'h123, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      add(FL, 4'd2, 12'h400 + 12'(k), 32'h4000 + 32'(k), 2'd2,
          1'b0, 3'(k), 32'h0, 2'd0, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(RD, 4'd2, 12'h400, 32'h0, 2'd0,          1'b1, 3'd0, 32'h4000, 2'd2, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b1);
    add(FL, 4'd2, 12'h410, 32'h4100, 2'd2,       1'b0, 3'd1, 32'h0,    2'd0, 1'b1, 12'h401, 1'b0, 1'b1, 1'b0, 1'b0);
    add(IV, 4'd2, 12'h404, 32'h0, 2'd0,          1'b1, 3'd4, 32'h0,    2'd2, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b0);
    add(RD, 4'd2, 12'h404, 32'h0, 2'd0,          1'b0, 3'd0, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 1'b1);
    add(FL, 4'd2, 12'h420, 32'h4200, 2'd2,       1'b0, 3'd4, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 1'b0);
    add(FL, 4'd2, 12'h420, 32'h4201, 2'd3,       1'b1, 3'd4, 32'h0,    2'd2, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b0);
    add(RD, 4'd2, 12'h420, 32'h0, 2'd0,          1'b1, 3'd4, 32'h4201, 2'd3, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 1'b1);
    add(WR, 4'd2, 12'h777, 32'h7777, 2'd0,       1'b0, 3'd0, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 1'b0);
    add(RD, 4'd2, 12'h777, 32'h0, 2'd0,          1'b0, 3'd0, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 1'b1);
    // Set 2 is full here; way 2 holds rank 7, so it is the victim of an invalid fill
    add(FL, 4'd2, 12'h500, 32'h5000, 2'd0,       1'b0, 3'd2, 32'h0,    2'd0, 1'b1, 12'h402, 1'b0, 1'b1, 1'b0, 1'b0);
    add(RD, 4'd2, 12'h500, 32'h0, 2'd0,          1'b0, 3'd0, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 1'b1);
    add(FL, 4'd2, 12'h501, 32'h5010, 2'd1,       1'b0, 3'd2, 32'h0,    2'd0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    reset_pulse("reset");

    foreach (vecs[i]) begin
      vec_t v;
      string nm;
      v = vecs[i];
      nm = $sformatf("v%0d", i);
      do_req(nm, v.op, v.idx, v.tag, v.data, v.st);
      chk({nm, ".hit"}, 64'(resp_hit), 64'(v.e_hit));
      if (v.cw) chk({nm, ".way"}, 64'(resp_way), 64'(v.e_way));
      if (v.cd) chk({nm, ".data"}, 64'(resp_data), 64'(v.e_data));
      if (v.cs) chk({nm, ".state"}, 64'(resp_state), 64'(v.e_st));
      chk({nm, ".evict_valid"}, 64'(evict_valid), 64'(v.e_ev));
      if (v.e_ev) begin
        chk({nm, ".evict_tag"}, 64'(evict_tag), 64'(v.e_evtag));
        chk({nm, ".evict_dirty"}, 64'(evict_dirty), 64'(v.e_evd));
      end
    end

    // One-cycle pulse; response fields hold afterwards
    @(negedge clk);
    chk("pulse.resp_valid_drop", 64'(resp_valid), 64'd0);
    chk("pulse.evict_valid_drop", 64'(evict_valid), 64'd0);
    chk("pulse.resp_way_hold", 64'(resp_way), 64'd2);

    // Abort a WRITE hit while it is in LOOKUP
    req_valid = 1'b1; req_op = WR; req_index = 4'd2; req_tag = 12'h420;
    req_data = 32'hBAD0; req_state = 2'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset_pulse("midreq");
`ifdef L2_STORE_STATS_EN
    chk("stats.hit_cleared", 64'(hit_count), 64'd0);
    chk("stats.miss_cleared", 64'(miss_count), 64'd0);
`endif
    do_req("after_abort", RD, 4'd2, 12'h420, 32'h0, 2'd0);
    chk("after_abort.hit", 64'(resp_hit), 64'd0);
    chk("after_abort.data", 64'(resp_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
